// File: rtl/ddr_rd_engine.sv
// AXI4 read master: issues a run of 64-byte INCR bursts and streams the returned
// beats out on AXI4-Stream, keeping beat/cycle/error statistics per command.
module ddr_rd_engine #(
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              RSTART_REG,
    input  logic [31:0]       RADDR_REG,
    input  logic [31:0]       RNBURST_REG,
    output logic              RIDLE_REG,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [3:0]        m_axi_arid,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [63:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [63:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [31:0]       beat_cnt,
    output logic [31:0]       cyc_cnt,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] MAX_O = 4'(MAX_OUTST);

    state_t            state_q;
    logic              ridle_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       nb_q, iss_q, done_q;
    logic [3:0]        outst_q, outst_d;
    logic [2:0]        bib_q;
    logic [31:0]       beat_q, cyc_q;
    logic              run, ar_hs, r_hs, r_end, r_bad;
    logic              unused_bits;

    assign unused_bits = &{1'b0, RNBURST_REG[31:16], RADDR_REG[5:0]};

    assign run   = (state_q == RUN);
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid & m_axi_rready;
    assign r_end = r_hs & m_axi_rlast;
    // rlast must coincide exactly with the 8th beat of a burst
    assign r_bad = (m_axi_rresp != 2'b00) | (m_axi_rlast != (bib_q == 3'd7));

    assign RIDLE_REG     = ridle_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd7;
    assign m_axi_arsize  = 3'd3;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = 4'd0;
    assign m_axi_arvalid = run && (iss_q < nb_q) && (outst_q < MAX_O);
    assign m_axi_rready  = m_axis_tready & run;
    assign m_axis_tvalid = m_axi_rvalid & run;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = m_axi_rlast & run & (done_q == nb_q - 16'd1);
    assign beat_cnt      = beat_q;
    assign cyc_cnt       = cyc_q;
    assign err           = err_q;

    always_comb begin
        outst_d = outst_q;
        if (ar_hs && !r_end)      outst_d = outst_q + 4'd1;
        else if (!ar_hs && r_end) outst_d = outst_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ridle_q <= 1'b1;
            addr_q  <= '0;
            nb_q    <= '0;
            iss_q   <= '0;
            done_q  <= '0;
            outst_q <= '0;
            bib_q   <= '0;
            beat_q  <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (RSTART_REG) begin
                        addr_q  <= ADDR_W'({RADDR_REG[31:6], 6'b0});
                        nb_q    <= RNBURST_REG[15:0];
                        iss_q   <= '0;
                        done_q  <= '0;
                        outst_q <= '0;
                        bib_q   <= '0;
                        beat_q  <= '0;
                        cyc_q   <= '0;
                        err_q   <= 1'b0;
                        ridle_q <= 1'b0;
                        // a zero-burst command resolves in RUN next cycle: RIDLE low for two cycles
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cyc_q   <= cyc_q + 32'd1;
                    outst_q <= outst_d;
                    if (ar_hs) begin
                        addr_q <= addr_q + ADDR_W'(64);
                        iss_q  <= iss_q + 16'd1;
                    end
                    if (r_hs) begin
                        beat_q <= beat_q + 32'd1;
                        bib_q  <= m_axi_rlast ? 3'd0 : bib_q + 3'd1;
                        err_q  <= err_q | r_bad;
                    end
                    if (r_end) done_q <= done_q + 16'd1;
                    if (done_q == nb_q) state_q <= DONE;
                end
                DONE: begin
                    cyc_q   <= cyc_q + 32'd1;
                    ridle_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
